// File: rtl/pc_step_sequencer_if.sv
// rtl/pc_step_sequencer_if.sv - control/status bundle between the step sequencer and the CPU datapath
interface pc_step_sequencer_if #(
  parameter int STEP_W = 3
);
  logic              run;
  logic              halt_req;
  logic              step_mode;
  logic [3:0]        ir_op;
  logic              flag_z;
  logic              flag_c;
  logic              pc_ldn;
  logic              pc_enp;
  logic              pc_ent;
  logic              mar_ld;
  logic              mem_rd;
  logic              ir_ld;
  logic              exec_en;
  logic [STEP_W-1:0] step;
  logic              busy;
  logic              halted;

  modport master (
    input  run, halt_req, step_mode, ir_op, flag_z, flag_c,
    output pc_ldn, pc_enp, pc_ent, mar_ld, mem_rd, ir_ld, exec_en, step, busy, halted
  );

  modport slave (
    output run, halt_req, step_mode, ir_op, flag_z, flag_c,
    input  pc_ldn, pc_enp, pc_ent, mar_ld, mem_rd, ir_ld, exec_en, step, busy, halted
  );
endinterface

// File: rtl/pc_step_sequencer.sv
// rtl/pc_step_sequencer.sv - T-state instruction sequencer driving PC counter pins and datapath strobes
module pc_step_sequencer #(
  parameter int         STEP_W = 3,
  parameter logic [3:0] OP_HLT = 4'hF,
  parameter logic [3:0] OP_JMP = 4'hC,
  parameter logic [3:0] OP_JZ  = 4'hD,
  parameter logic [3:0] OP_JC  = 4'hE,
  parameter logic [3:0] OP_NOP = 4'h0
) (
  input logic                  CLK,
  input logic                  CLRn,
  pc_step_sequencer_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, HALTED} state_t;

  localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
  localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
  localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
  localparam logic [STEP_W-1:0] T4 = STEP_W'(4);

  state_t            state, state_nxt;
  logic [STEP_W-1:0] step, step_nxt;
  logic              run_q;
  logic              flag_z_q, flag_c_q;

  logic start, is_jump, is_short, taken, last;

  assign start    = bus.run & ~run_q;
  assign is_jump  = (bus.ir_op == OP_JMP) || (bus.ir_op == OP_JZ) || (bus.ir_op == OP_JC);
  assign is_short = (bus.ir_op == OP_NOP) || (bus.ir_op == OP_HLT);
  assign taken    = (bus.ir_op == OP_JMP) ||
                    ((bus.ir_op == OP_JZ) && flag_z_q) ||
                    ((bus.ir_op == OP_JC) && flag_c_q);
  assign last     = ((step == T2) && is_short) || ((step == T3) && is_jump) || (step == T4);

  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      state    <= IDLE;
      step     <= T0;
      run_q    <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      run_q <= bus.run;
      // Flags are captured on the edge into T3 so the T3 jump decode stays purely registered.
      if (state == RUN && step == T2) begin
        flag_z_q <= bus.flag_z;
        flag_c_q <= bus.flag_c;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    case (state)
      IDLE, PAUSE, HALTED: begin
        step_nxt = T0;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (step > T4) begin
          step_nxt = T0;
        end else if (last) begin
          step_nxt = T0;
          if (bus.ir_op == OP_HLT || bus.halt_req) state_nxt = HALTED;
          else if (bus.step_mode)                  state_nxt = PAUSE;
        end else begin
          step_nxt = step + STEP_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        step_nxt  = T0;
      end
    endcase
  end

  always_comb begin
    bus.pc_ldn  = 1'b1;
    bus.pc_enp  = 1'b0;
    bus.pc_ent  = 1'b0;
    bus.mar_ld  = 1'b0;
    bus.mem_rd  = 1'b0;
    bus.ir_ld   = 1'b0;
    bus.exec_en = 1'b0;
    if (state == RUN) begin
      case (step)
        T0: bus.mar_ld = 1'b1;
        T1: begin
          bus.mem_rd = 1'b1;
          bus.ir_ld  = 1'b1;
          bus.pc_enp = 1'b1;
          bus.pc_ent = 1'b1;
        end
        T2: begin
          if (is_jump)        bus.mar_ld  = 1'b1;
          else if (!is_short) bus.exec_en = 1'b1;
        end
        T3: begin
          if (is_jump) begin
            bus.mem_rd = 1'b1;
            if (taken) begin
              bus.pc_ldn = 1'b0;
            end else begin
              bus.pc_enp = 1'b1;
              bus.pc_ent = 1'b1;
            end
          end else if (!is_short) begin
            bus.exec_en = 1'b1;
          end
        end
        T4: bus.exec_en = !is_jump && !is_short;
        default: ;
      endcase
    end
  end

  assign bus.step   = step;
  assign bus.busy   = (state == RUN);
  assign bus.halted = (state == HALTED);

endmodule
